// File: rtl/bp_update_scheduler.sv
// In-order update FIFO between ROB retire and the branch predictor. Groups are split so that
// no two lanes in one cycle hit the same predictor row. Optional statistics: BP_SCHED_STATS_EN.
module bp_update_scheduler #(
  parameter int N        = 2,
  parameter int DEPTH    = 8,
  parameter int IDX_BITS = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N-1:0]                 in_valid,
  input  logic [N*32-1:0]              in_pc,
  input  logic [N-1:0]                 in_taken,
  input  logic [N*32-1:0]              in_target,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         upd_stall,
  output logic [N-1:0]                 out_valid,
  output logic [N*32-1:0]              out_pc,
  output logic [N-1:0]                 out_taken,
  output logic [N*32-1:0]              out_target,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [1:0]                   dbg_state
`ifdef BP_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_taken,
  output logic [31:0]                  stat_split
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic [31:0]     r_pc_mem [DEPTH];
  logic [31:0]     r_tg_mem [DEPTH];
  logic [DEPTH-1:0] r_tk_mem;

  logic [PW-1:0]       w_rd_ptr [N];
  logic [PW-1:0]       w_wr_ptr [N];
  logic [IDX_BITS-1:0] w_idx [N];
  logic [CW-1:0]       w_k, w_enq_n, w_deq_n, w_count_nx;
  logic [PW-1:0]       w_tail_nx, w_head_nx;
  logic                w_conflict;

  // Issue group: take head entries in order, stop at the first one whose row repeats.
  always_comb begin
    w_k        = '0;
    w_conflict = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_rd_ptr[j] = r_head + PW'(j);
      w_idx[j]    = r_pc_mem[w_rd_ptr[j]][IDX_BITS+1:2];
    end
    for (int j = 0; j < N; j++) begin
      if (!w_conflict && (CW'(j) < r_count)) begin
        for (int m = 0; m < j; m++) begin
          if (w_idx[m] == w_idx[j]) w_conflict = 1'b1;
        end
        if (!w_conflict) w_k = CW'(j + 1);
      end
    end
  end

  always_comb begin
    out_valid  = '0;
    out_pc     = '0;
    out_taken  = '0;
    out_target = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = (CW'(i) < w_k);
      if (out_valid[i]) begin
        out_pc[i*32 +: 32]     = r_pc_mem[w_rd_ptr[i]];
        out_taken[i]           = r_tk_mem[w_rd_ptr[i]];
        out_target[i*32 +: 32] = r_tg_mem[w_rd_ptr[i]];
      end
    end
  end

  // Valid lanes are compacted: lane i lands after all lower valid lanes.
  always_comb begin
    w_enq_n = '0;
    for (int i = 0; i < N; i++) begin
      w_wr_ptr[i] = r_tail + PW'(w_enq_n);
      if (in_valid[i]) w_enq_n = w_enq_n + CW'(1);
    end
    if (!r_in_ready) w_enq_n = '0;
  end

  // Flush forces the group out even if the predictor is stalling.
  assign w_deq_n    = (!upd_stall || flush) ? w_k : '0;
  assign w_count_nx = r_count + w_enq_n - w_deq_n;
  assign w_tail_nx  = r_tail + PW'(w_enq_n);
  assign w_head_nx  = r_head + PW'(w_deq_n);

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset && r_in_ready && in_valid[i]) begin
        r_pc_mem[w_wr_ptr[i]] <= in_pc[i*32 +: 32];
        r_tg_mem[w_wr_ptr[i]] <= in_target[i*32 +: 32];
        r_tk_mem[w_wr_ptr[i]] <= in_taken[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
    end else begin
      r_tail <= w_tail_nx;
      if (flush) begin
        r_head     <= w_tail_nx;
        r_count    <= '0;
        r_state    <= S_FLUSH;
        r_in_ready <= 1'b0;
      end else begin
        r_head     <= w_head_nx;
        r_count    <= w_count_nx;
        r_in_ready <= (w_count_nx <= CW'(DEPTH - N));
        case (r_state)
          S_IDLE:  if (w_count_nx != '0) r_state <= S_DRAIN;
          S_DRAIN: if (w_count_nx == '0) r_state <= S_IDLE;
          default: r_state <= (w_count_nx != '0) ? S_DRAIN : S_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign count     = r_count;
  assign dbg_state = r_state;

  a_no_enq_when_not_ready: assert property (@(posedge clock) disable iff (reset)
    !((|in_valid) && !r_in_ready));

`ifdef BP_SCHED_STATS_EN
  logic [31:0] r_stat_issued, r_stat_taken, r_stat_split;
  logic [CW-1:0] w_deq_taken;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    w_deq_taken = '0;
    for (int i = 0; i < N; i++) begin
      if ((CW'(i) < w_deq_n) && out_taken[i]) w_deq_taken = w_deq_taken + CW'(1);
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_issued <= '0;
      r_stat_taken  <= '0;
      r_stat_split  <= '0;
    end else begin
      r_stat_issued <= sat_add(r_stat_issued, w_deq_n);
      r_stat_taken  <= sat_add(r_stat_taken, w_deq_taken);
      if ((w_deq_n != '0) && w_conflict && (r_count > w_k))
        r_stat_split <= sat_add(r_stat_split, CW'(1));
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_taken  = r_stat_taken;
  assign stat_split  = r_stat_split;
`endif
endmodule
